// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host receiver: synchronises the raw pins, decodes 11-bit frames,
// buffers good bytes in a small FIFO and exposes data/status/irq to the CPU port decoder.
module ps2_keyboard #(
  parameter int AW      = 3,
  parameter int TIMEOUT = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       rd,
  input  logic       clr,
  output logic [7:0] data,
  output logic [7:0] status,
  output logic       irq
);

  localparam int            DEPTH    = 2 ** AW;
  localparam int            TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic {IDLE, RECV} state_t;

  logic [2:0]    clk_sync_r;
  logic [1:0]    dat_sync_r;
  state_t        state_r;
  logic [3:0]    cnt_r;
  logic [7:0]    shift_r;
  logic          parity_r;
  logic [TW-1:0] idle_cnt_r;
  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [AW:0]   count_r;
  logic          overflow_r;
  logic          frame_err_r;

  logic fall_s, dat_s, busy_s, done_s, valid_s, timeout_s;
  logic full_s, ready_s, push_s, pop_s, ovf_set_s, ferr_set_s;

  // Frame events and FIFO handshakes, all derived from registered state.
  always_comb begin
    fall_s     = clk_sync_r[2] & ~clk_sync_r[1];
    dat_s      = dat_sync_r[1];
    busy_s     = (state_r == RECV);
    done_s     = busy_s & fall_s & (cnt_r == 4'd9);
    valid_s    = dat_s & (^shift_r ^ parity_r);
    timeout_s  = busy_s & ~fall_s & (idle_cnt_r == TMAX);
    full_s     = (count_r == FULL_CNT);
    ready_s    = (count_r != {(AW + 1){1'b0}});
    push_s     = done_s & valid_s & ~full_s;
    ovf_set_s  = done_s & valid_s & full_s;
    ferr_set_s = (done_s & ~valid_s) | timeout_s;
    pop_s      = rd & ready_s;
  end

  // Two-stage synchronisers; the extra clock stage gives the falling-edge detector its history.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_r <= 3'b111;
      dat_sync_r <= 2'b11;
    end else begin
      clk_sync_r <= {clk_sync_r[1:0], ps2_clk};
      dat_sync_r <= {dat_sync_r[0], ps2_dat};
    end
  end

  // Frame FSM: start bit, 8 data bits LSB first, parity, stop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      shift_r  <= 8'h00;
      parity_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (fall_s && !dat_s) begin
            state_r <= RECV;
            cnt_r   <= 4'd0;
            shift_r <= 8'h00;
          end else begin
            state_r <= IDLE;
          end
        end
        RECV: begin
          if (fall_s) begin
            if (cnt_r < 4'd8) begin
              shift_r <= {dat_s, shift_r[7:1]};
            end else if (cnt_r == 4'd8) begin
              parity_r <= dat_s;
            end else begin
              state_r <= IDLE;
            end
            cnt_r <= cnt_r + 4'd1;
          end else if (timeout_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= RECV;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Cycles since the last PS/2 falling edge, saturating.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt_r <= {TW{1'b0}};
    end else if (fall_s) begin
      idle_cnt_r <= {TW{1'b0}};
    end else if (idle_cnt_r != TMAX) begin
      idle_cnt_r <= idle_cnt_r + TW'(1);
    end else begin
      idle_cnt_r <= idle_cnt_r;
    end
  end

  // FIFO storage needs no reset; reads are gated by ready.
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_r[wptr_r] <= shift_r;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {(AW + 1){1'b0}};
    end else begin
      wptr_r <= push_s ? wptr_r + AW'(1) : wptr_r;
      rptr_r <= pop_s ? rptr_r + AW'(1) : rptr_r;
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky error flags; a new event wins over a coincident clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      overflow_r  <= ovf_set_s ? 1'b1 : (clr ? 1'b0 : overflow_r);
      frame_err_r <= ferr_set_s ? 1'b1 : (clr ? 1'b0 : frame_err_r);
    end
  end

  assign data   = ready_s ? mem_r[rptr_r] : 8'h00;
  assign status = {3'b000, busy_s, frame_err_r, overflow_r, full_s, ready_s};
  assign irq    = ready_s;

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: directed scenarios plus random frames,
// compared against a queue-based model of the receiver's externally visible behaviour.
module tb_ps2_keyboard;

  localparam int AW      = 3;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 400;
  localparam int HP      = 20;

  logic       clock   = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rd      = 1'b0;
  logic       clr     = 1'b0;
  logic [7:0] data;
  logic [7:0] status;
  logic       irq;

  int checks = 0;
  int errors = 0;

  byte unsigned q[$];
  bit           m_ovf  = 1'b0;
  bit           m_ferr = 1'b0;

  ps2_keyboard #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .ps2_clk(ps2_clk),
    .ps2_dat(ps2_dat),
    .rd     (rd),
    .clr    (clr),
    .data   (data),
    .status (status),
    .irq    (irq)
  );

  always #20 clock = ~clock;

  initial begin
    #5000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] ed;
    logic [7:0] es;
    bit         nonempty;
    nonempty = (q.size() != 0);
    if (nonempty) ed = q[0];
    else          ed = 8'h00;
    es = {3'b000, 1'b0, m_ferr, m_ovf, q.size() == DEPTH, nonempty};
    check({tag, ".status"}, status, es);
    check({tag, ".data"}, data, ed);
    check({tag, ".irq"}, {7'b0, irq}, {7'b0, nonempty});
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic drive_bit(input bit b, input bit stay_low);
    @(negedge clock);
    ps2_dat = b;
    wait_clk(HP);
    ps2_clk = 1'b0;
    if (!stay_low) begin
      wait_clk(HP);
      ps2_clk = 1'b1;
    end
  endtask

  // Drives the first nbits of a frame; the clock is left low after the last falling edge.
  task automatic frame_head(input byte unsigned b, input bit par_ok, input bit stop,
                            input int nbits = 11);
    logic [10:0] bits;
    bit          par;
    par  = par_ok ? ~(^b) : ^b;
    bits = {stop, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) drive_bit(bits[i], i == nbits - 1);
  endtask

  task automatic frame_tail();
    wait_clk(HP);
    ps2_dat = 1'b1;
    ps2_clk = 1'b1;
    wait_clk(HP);
  endtask

  task automatic model_frame(input byte unsigned b, input bit par_ok, input bit stop);
    if (!stop || !par_ok) m_ferr = 1'b1;
    else if (q.size() == DEPTH) m_ovf = 1'b1;
    else q.push_back(b);
  endtask

  task automatic send(input byte unsigned b, input bit par_ok, input bit stop);
    frame_head(b, par_ok, stop);
    frame_tail();
    model_frame(b, par_ok, stop);
  endtask

  task automatic pulse_rd();
    @(negedge clock);
    rd = 1'b1;
    @(negedge clock);
    rd = 1'b0;
    if (q.size() != 0) q.delete(0);
  endtask

  task automatic pulse_clr();
    @(negedge clock);
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
  endtask

  initial begin
    byte unsigned b;
    int           kind;

    wait_clk(3);
    check_model("reset");
    @(negedge clock);
    reset_n = 1'b1;
    wait_clk(2);

    // Single frame 0x1C with exact pin-to-status latency.
    frame_head(8'h1C, 1'b1, 1'b1);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("t1.before_n2", status, 8'h10);
    @(posedge clock);
    @(negedge clock);
    model_frame(8'h1C, 1'b1, 1'b1);
    check_model("t1.after_n2");
    frame_tail();
    pulse_rd();
    check_model("t1.pop");

    // Two frames, then pops including one while empty.
    send(8'hF0, 1'b1, 1'b1);
    send(8'h1C, 1'b1, 1'b1);
    check_model("t2.two");
    pulse_rd();
    check_model("t2.pop1");
    pulse_rd();
    check_model("t2.pop2");
    pulse_rd();
    check_model("t2.pop_empty");

    // Fill past capacity with random bytes.
    for (int i = 0; i < 9; i++) begin
      send(8'($urandom_range(0, 255)), 1'b1, 1'b1);
      check_model($sformatf("t3.fill%0d", i));
    end
    b = 8'($urandom_range(0, 255));
    frame_head(b, 1'b1, 1'b1);
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
    model_frame(b, 1'b1, 1'b1);
    frame_tail();
    check_model("t3.clr_vs_ovf");
    for (int i = 0; i < 8; i++) begin
      pulse_rd();
      check_model($sformatf("t3.drain%0d", i));
    end
    pulse_clr();
    check_model("t3.clr");

    // Bad parity, then bad stop bit.
    send(8'h1C, 1'b0, 1'b1);
    check_model("t4.parity");
    send(8'h1C, 1'b1, 1'b0);
    check_model("t4.stop");
    pulse_clr();
    check_model("t4.clr");

    // Partial frame abandoned by the idle timeout.
    frame_head(8'h0F, 1'b1, 1'b1, 5);
    wait_clk(HP);
    ps2_clk = 1'b1;
    wait_clk(5);
    check("t5.busy", status, 8'h10);
    wait_clk(TIMEOUT / 2);
    check("t5.busy_mid", status, 8'h10);
    wait_clk(TIMEOUT);
    m_ferr = 1'b1;
    check_model("t5.timeout");
    send(8'h5A, 1'b1, 1'b1);
    check_model("t5.after");
    pulse_rd();
    pulse_clr();
    check_model("t5.clean");

    // Random mix of good and bad frames with interleaved pops and clears.
    for (int k = 0; k < 12; k++) begin
      kind = $urandom_range(0, 3);
      b    = 8'($urandom_range(0, 255));
      send(b, kind != 2, kind != 3);
      if ($urandom_range(0, 1) == 1) pulse_rd();
      if ($urandom_range(0, 4) == 0) pulse_clr();
      check_model($sformatf("rnd%0d", k));
    end

    // Reset mid-frame with three bytes buffered.
    while (q.size() != 0) pulse_rd();
    pulse_clr();
    for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)), 1'b1, 1'b1);
    check_model("t6.three");
    frame_head(8'($urandom_range(0, 255)), 1'b1, 1'b1, 4);
    #7;
    reset_n = 1'b0;
    #1;
    q.delete();
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
    check_model("t6.async_reset");
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    wait_clk(10);
    reset_n = 1'b1;
    wait_clk(5);
    send(8'h29, 1'b1, 1'b1);
    check_model("t6.after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
